proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Synthesizable run controller and instruction watcher for the single-cycle processor. It generates a stretched processor reset and counts run cycles. It matches the fetched instruction against NUM_WATCH masked patterns, keeping per-pattern hit counts, and decides when a program has finished: halt instruction, self-loop, or cycle limit. It sits between the top level and `processor`, observing `iaddr`/`inst_from_mem`, and replaces ad-hoc halt and print logic in benches and on FPGA builds.

## Interface
Parameters:
- RESET_CYCLES, 2: cycles `proc_reset` stays high after `reset` falls (≥1).
- NUM_WATCH, 2: number of watch channels (1–8).
- CNT_W, 32: width of cycle and watch counters.
- HALT_INSTR, 32'h0000000d: encoding that ends the run (MIPS `break`).
- HALT_REPEAT, 4: consecutive cycles with unchanged `iaddr` that count as a self-loop halt (≥2).
- MAX_CYCLES, 0: run-cycle limit; 0 disables the limit.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; restarts the whole run.
- iaddr  in  32  instruction address from processor.
- instr  in  32  instruction word from imem.
- watch_pattern  in  NUM_WATCH*32  channel k at bits [k*32 +: 32].
- watch_mask  in  NUM_WATCH*32  1 = compare bit, 0 = don't care.
- proc_reset  out  1  reset to processor.
- running  out  1  high in RUN.
- done  out  1  sticky; high in DONE.
- halt_cause  out  2  00 none, 01 halt instr, 10 self-loop, 11 cycle limit.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- watch_hit  out  NUM_WATCH  one-cycle pulse per channel match.
- watch_count  out  NUM_WATCH*CNT_W  per-channel hit counts.

## Operation
- States: HOLD, RUN, DONE. `reset` high forces HOLD, hold counter=0, all counters=0, `halt_cause`=00, repeat counter=0. Reset values: `proc_reset`=1, `running`=0, `done`=0, `watch_hit`=0.
- HOLD: `proc_reset`=1. Hold counter increments each cycle with `reset` low. On reaching RESET_CYCLES it goes to RUN.
- RUN: `proc_reset`=0, `running`=1. Each cycle `cycle_count` increments and saturates at all-ones.
  - Channel k matches when `(instr ^ pattern_k) & mask_k == 0`. A match pulses `watch_hit[k]` and increments `watch_count[k]`, saturating.
  - An all-zero mask matches every RUN cycle.
- Self-loop detection: `prev_iaddr` is registered every RUN cycle. The repeat counter increments when `iaddr == prev_iaddr` and clears otherwise. The comparison is invalid on the first RUN cycle.
- Halt evaluation, in one cycle:
  - `instr == HALT_INSTR` gives cause 01.
  - Repeat counter reaching HALT_REPEAT-1 with a current repeat gives cause 10.
  - MAX_CYCLES≠0 and the post-increment `cycle_count == MAX_CYCLES` gives cause 11.
  - Priority when simultaneous: 01 > 10 > 11. The halting cycle is itself counted and watched.
- DONE: `done`=1, `running`=0, `proc_reset`=0. All counters, `halt_cause` and `done` freeze until `reset`. `watch_hit`=0.
- `reset` asserted in any state, including mid-RUN, takes effect on the next edge with the reset values above.

## Timing
- All outputs are registered. A match on the instr sampled at edge N shows `watch_hit` high and the updated count from N+1 for one cycle.
- `reset` low at edge 0 gives `proc_reset` falling after edge RESET_CYCLES. The first RUN sample is at edge RESET_CYCLES+1.
- `done` and `halt_cause` are valid one cycle after the halting sample. `cycle_count` at that point includes the halting cycle.
- Watch pattern and mask inputs are sampled every cycle and may change freely. A change applies from the next sample.

## Configuration
- `PROC_RUN_CTRL_WATCH_COUNT_EN` defined: per-channel `watch_count` counters are built.
- Not defined: no counters. `watch_count` is tied to 0, while `watch_hit` and all halt logic still operate.

## Test plan
- Defaults, `reset` for 2 cycles then low: `proc_reset` is high for exactly 2 further cycles, then `running`=1 and `cycle_count` counts 1,2,3…
- `instr`=32'h0000000d on the 10th RUN cycle: `done`=1, `halt_cause`=01 and `cycle_count`=10 one cycle later, frozen afterwards.
- `iaddr` held at 32'h40 from RUN cycle 5 onward: the repeat starts at cycle 6. `done` is set with `halt_cause`=10 after cycle 8, giving `cycle_count`=8.
- Watch 0 pattern 32'hac000000 with mask 32'hfc000000 (sw), watch 1 exact 32'h8cc42000. Drive 3 sw instructions and 2 of the exact word: `watch_count`=3 and 2, one `watch_hit` pulse per match. With the macro undefined, counts read 0.
- MAX_CYCLES=20 and a halt instruction on cycle 20: `halt_cause`=01 wins. With no halt instruction: cause 11, `cycle_count`=20.
- `reset` pulsed at RUN cycle 7 with counts nonzero: the next cycle returns to HOLD, with counters 0, `proc_reset`=1 and `done`=0.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// -----------------------------------------------------------------------------
// proc_run_ctrl
// Run controller and instruction watcher for the single-cycle processor.
//  - Stretches the processor reset for RESET_CYCLES after `reset` falls.
//  - Counts RUN cycles (saturating) and matches the fetched instruction
//    against NUM_WATCH masked patterns, pulsing watch_hit on each match.
//  - Ends the run on a halt instruction, an iaddr self-loop or a cycle limit,
//    then freezes all status until the next `reset`.
// Build option: define PROC_RUN_CTRL_WATCH_COUNT_EN to build the per-channel
// saturating hit counters; otherwise watch_count reads as zero.
// -----------------------------------------------------------------------------
module proc_run_ctrl #(
    parameter int          RESET_CYCLES = 2,
    parameter int          NUM_WATCH    = 2,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] HALT_INSTR   = 32'h0000000d,
    parameter int          HALT_REPEAT  = 4,
    parameter int          MAX_CYCLES   = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                iaddr,
    input  logic [31:0]                instr,
    input  logic [NUM_WATCH*32-1:0]    watch_pattern,
    input  logic [NUM_WATCH*32-1:0]    watch_mask,
    output logic                       proc_reset,
    output logic                       running,
    output logic                       done,
    output logic [1:0]                 halt_cause,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [NUM_WATCH-1:0]       watch_hit,
    output logic [NUM_WATCH*CNT_W-1:0] watch_count
);

    // Hold counter must reach RESET_CYCLES; repeat counter must reach HALT_REPEAT-1.
    localparam int HOLD_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(HALT_REPEAT - 1);
    localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_HALT  = 2'b01;
    localparam logic [1:0] CAUSE_LOOP  = 2'b10;
    localparam logic [1:0] CAUSE_LIMIT = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                 state_r;
    logic [HOLD_W-1:0]      hold_cnt_r;
    logic [31:0]            prev_iaddr_r;
    logic                   prev_valid_r;
    logic [REP_W-1:0]       rep_cnt_r;

    logic [NUM_WATCH-1:0]   match_s;
    logic [CNT_W-1:0]       cycle_next_s;
    logic                   addr_repeat_s;
    logic [REP_W-1:0]       rep_next_s;
    logic                   hit_halt_s;
    logic                   hit_loop_s;
    logic                   hit_limit_s;
    logic [1:0]             cause_next_s;

    // Saturating increment shared by the cycle and watch counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Masked compare: a mask bit of 1 makes the corresponding bit significant.
    function automatic logic match_word(input logic [31:0] word,
                                        input logic [31:0] pattern,
                                        input logic [31:0] mask);
        return (((word ^ pattern) & mask) == 32'd0);
    endfunction

    // Per-channel masked match of the currently fetched instruction.
    always_comb begin
        match_s = '0;
        for (int k = 0; k < NUM_WATCH; k++) begin
            match_s[k] = match_word(instr, watch_pattern[k*32 +: 32], watch_mask[k*32 +: 32]);
        end
    end

    // Halt decision for the current RUN sample; halt instr beats self-loop beats limit.
    always_comb begin
        cycle_next_s  = sat_inc(cycle_count);
        addr_repeat_s = prev_valid_r && (iaddr == prev_iaddr_r);
        if (addr_repeat_s) begin
            rep_next_s = rep_cnt_r + REP_W'(1);
        end else begin
            rep_next_s = '0;
        end
        hit_halt_s  = (instr == HALT_INSTR);
        hit_loop_s  = addr_repeat_s && (rep_next_s == REP_LAST);
        hit_limit_s = (MAX_CYCLES != 0) && (cycle_next_s == CYC_LIMIT);
        if (hit_halt_s) begin
            cause_next_s = CAUSE_HALT;
        end else if (hit_loop_s) begin
            cause_next_s = CAUSE_LOOP;
        end else if (hit_limit_s) begin
            cause_next_s = CAUSE_LIMIT;
        end else begin
            cause_next_s = CAUSE_NONE;
        end
    end

    // Run-control FSM: reset stretch, run bookkeeping, halt capture and freeze.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_HOLD;
            hold_cnt_r   <= '0;
            proc_reset   <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            halt_cause   <= CAUSE_NONE;
            cycle_count  <= '0;
            watch_hit    <= '0;
            prev_iaddr_r <= 32'd0;
            prev_valid_r <= 1'b0;
            rep_cnt_r    <= '0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    watch_hit <= '0;
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r    <= ST_RUN;
                        proc_reset <= 1'b0;
                        running    <= 1'b1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        proc_reset <= 1'b1;
                        running    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The halting cycle is still counted and watched.
                    cycle_count  <= cycle_next_s;
                    watch_hit    <= match_s;
                    prev_iaddr_r <= iaddr;
                    prev_valid_r <= 1'b1;
                    rep_cnt_r    <= rep_next_s;
                    if (cause_next_s != CAUSE_NONE) begin
                        state_r    <= ST_DONE;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        halt_cause <= cause_next_s;
                    end else begin
                        running    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Everything frozen until reset; only the hit pulse is cleared.
                    watch_hit  <= '0;
                    running    <= 1'b0;
                    done       <= 1'b1;
                    proc_reset <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fall back to holding the processor in reset.
                    state_r    <= ST_HOLD;
                    hold_cnt_r <= '0;
                    proc_reset <= 1'b1;
                    running    <= 1'b0;
                    done       <= 1'b0;
                    watch_hit  <= '0;
                end
            endcase
        end
    end

`ifdef PROC_RUN_CTRL_WATCH_COUNT_EN
    // Per-channel saturating hit counters, advancing only on RUN samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            watch_count <= '0;
        end else if (state_r == ST_RUN) begin
            for (int k = 0; k < NUM_WATCH; k++) begin
                if (match_s[k]) begin
                    watch_count[k*CNT_W +: CNT_W] <= sat_inc(watch_count[k*CNT_W +: CNT_W]);
                end else begin
                    watch_count[k*CNT_W +: CNT_W] <= watch_count[k*CNT_W +: CNT_W];
                end
            end
        end else begin
            watch_count <= watch_count;
        end
    end
`else
    assign watch_count = {(NUM_WATCH*CNT_W){1'b0}};
`endif

endmodule

// File: tb/tb_proc_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_proc_run_ctrl
// Scoreboard bench: each driven cycle pushes the expected outputs, which are
// popped and compared one clock later. dut uses defaults; dut_max has
// MAX_CYCLES=20 and shares all inputs.
// -----------------------------------------------------------------------------
module tb_proc_run_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] iaddr = 32'd0;
    logic [31:0] instr = 32'd0;
    logic [63:0] watch_pattern = 64'd0;
    logic [63:0] watch_mask    = 64'd0;

    logic        proc_reset, running, done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic [1:0]  watch_hit;
    logic [63:0] watch_count;

    logic        m_proc_reset, m_running, m_done;
    logic [1:0]  m_halt_cause;
    logic [31:0] m_cycle_count;
    logic [1:0]  m_watch_hit;
    logic [63:0] m_watch_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic        prst;
        logic        run;
        logic        dn;
        logic [1:0]  cause;
        logic [31:0] cc;
        logic [1:0]  hit;
        logic [31:0] c0;
        logic [31:0] c1;
        bit          on_max;
    } exp_t;

    exp_t sb_q[$];

    proc_run_ctrl dut (
        .clock(clock), .reset(reset), .iaddr(iaddr), .instr(instr),
        .watch_pattern(watch_pattern), .watch_mask(watch_mask),
        .proc_reset(proc_reset), .running(running), .done(done),
        .halt_cause(halt_cause), .cycle_count(cycle_count),
        .watch_hit(watch_hit), .watch_count(watch_count)
    );

    proc_run_ctrl #(.MAX_CYCLES(20)) dut_max (
        .clock(clock), .reset(reset), .iaddr(iaddr), .instr(instr),
        .watch_pattern(watch_pattern), .watch_mask(watch_mask),
        .proc_reset(m_proc_reset), .running(m_running), .done(m_done),
        .halt_cause(m_halt_cause), .cycle_count(m_cycle_count),
        .watch_hit(m_watch_hit), .watch_count(m_watch_count)
    );

    always #5 clock = ~clock;

    // Expected watch count: counters only exist when the build option is on.
    function automatic int wc(input int n);
`ifdef PROC_RUN_CTRL_WATCH_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic exp_t mk(input string tag, input logic prst, input logic run,
                                input logic dn, input logic [1:0] cause, input int cc,
                                input logic [1:0] hit, input int c0, input int c1,
                                input bit on_max);
        exp_t e;
        e.tag = tag; e.prst = prst; e.run = run; e.dn = dn; e.cause = cause;
        e.cc = 32'(cc); e.hit = hit; e.c0 = 32'(wc(c0)); e.c1 = 32'(wc(c1));
        e.on_max = on_max;
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pop the oldest expectation and compare it with the selected DUT.
    task automatic compare_head();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            if (e.on_max) begin
                check_val({e.tag, ".prst"},  64'(m_proc_reset), 64'(e.prst));
                check_val({e.tag, ".run"},   64'(m_running), 64'(e.run));
                check_val({e.tag, ".done"},  64'(m_done), 64'(e.dn));
                check_val({e.tag, ".cause"}, 64'(m_halt_cause), 64'(e.cause));
                check_val({e.tag, ".cc"},    64'(m_cycle_count), 64'(e.cc));
                check_val({e.tag, ".hit"},   64'(m_watch_hit), 64'(e.hit));
                check_val({e.tag, ".wc0"},   64'(m_watch_count[31:0]), 64'(e.c0));
                check_val({e.tag, ".wc1"},   64'(m_watch_count[63:32]), 64'(e.c1));
            end else begin
                check_val({e.tag, ".prst"},  64'(proc_reset), 64'(e.prst));
                check_val({e.tag, ".run"},   64'(running), 64'(e.run));
                check_val({e.tag, ".done"},  64'(done), 64'(e.dn));
                check_val({e.tag, ".cause"}, 64'(halt_cause), 64'(e.cause));
                check_val({e.tag, ".cc"},    64'(cycle_count), 64'(e.cc));
                check_val({e.tag, ".hit"},   64'(watch_hit), 64'(e.hit));
                check_val({e.tag, ".wc0"},   64'(watch_count[31:0]), 64'(e.c0));
                check_val({e.tag, ".wc1"},   64'(watch_count[63:32]), 64'(e.c1));
            end
        end
    endtask

    task automatic run_cycle(input logic [31:0] ins, input logic [31:0] addr, input exp_t e);
        instr = ins;
        iaddr = addr;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        compare_head();
    endtask

    // Two reset cycles, then the stretched processor reset, ending in RUN with cc=0.
    task automatic start_run(input string tag, input bit on_max);
        reset = 1'b1;
        for (int i = 0; i < 2; i++)
            run_cycle(32'd0, 32'd0, mk({tag, ".rst"}, 1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, 0, 0, on_max));
        reset = 1'b0;
        run_cycle(32'd0, 32'd0, mk({tag, ".hold0"}, 1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, 0, 0, on_max));
        run_cycle(32'd0, 32'd0, mk({tag, ".hold1"}, 1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, 0, 0, on_max));
        run_cycle(32'd0, 32'd0, mk({tag, ".go"},    1'b0, 1'b1, 1'b0, 2'd0, 0, 2'b00, 0, 0, on_max));
    endtask

    logic [31:0] w_instr [8];
    logic [1:0]  w_hit   [8];

    initial begin
        // Channel 0 never matches; channel 1 has an all-zero mask (matches every RUN cycle).
        watch_pattern = {32'h12345678, 32'hffffffff};
        watch_mask    = {32'h00000000, 32'hffffffff};

        // Reset stretch, counting, halt instruction on RUN cycle 10, then freeze.
        start_run("t1", 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k < 10)
                run_cycle(32'd0, 32'h100 + 32'(4*k),
                          mk($sformatf("t1.c%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, k, 2'b10, 0, k, 1'b0));
            else if (k == 10)
                run_cycle(32'h0000000d, 32'h100 + 32'(4*k),
                          mk($sformatf("t1.c%0d", k), 1'b0, 1'b0, 1'b1, 2'd1, 10, 2'b10, 0, 10, 1'b0));
            else
                run_cycle(32'h0000000d, 32'h100 + 32'(4*k),
                          mk($sformatf("t1.frz%0d", k), 1'b0, 1'b0, 1'b1, 2'd1, 10, 2'b00, 0, 10, 1'b0));
        end

        // Self-loop: iaddr stuck at 0x40 from RUN cycle 5, halt after cycle 8.
        watch_pattern = {32'hffffffff, 32'hffffffff};
        watch_mask    = {32'hffffffff, 32'hffffffff};
        start_run("t3", 1'b0);
        for (int k = 1; k <= 11; k++) begin
            if (k < 8)
                run_cycle(32'd0, (k >= 5) ? 32'h40 : 32'h100 + 32'(4*k),
                          mk($sformatf("t3.c%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, k, 2'b00, 0, 0, 1'b0));
            else
                run_cycle(32'd0, 32'h40,
                          mk($sformatf("t3.c%0d", k), 1'b0, 1'b0, 1'b1, 2'd2, 8, 2'b00, 0, 0, 1'b0));
        end

        // Watch channels: sw opcode class on ch0, exact lw word on ch1.
        watch_pattern = {32'h8cc42000, 32'hac000000};
        watch_mask    = {32'hffffffff, 32'hfc000000};
        w_instr = '{32'hac010004, 32'h00000000, 32'h8cc42000, 32'hafbf0010,
                    32'h8cc42004, 32'hac220000, 32'h8cc42000, 32'h00000020};
        w_hit   = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        start_run("t4", 1'b0);
        begin
            int c0 = 0;
            int c1 = 0;
            for (int k = 0; k < 8; k++) begin
                if (w_hit[k][0]) c0++;
                if (w_hit[k][1]) c1++;
                run_cycle(w_instr[k], 32'h200 + 32'(4*k),
                          mk($sformatf("t4.c%0d", k+1), 1'b0, 1'b1, 1'b0, 2'd0, k+1, w_hit[k], c0, c1, 1'b0));
            end
            check_val("t4.total_sw", 64'(c0), 64'd3);
            check_val("t4.total_lw", 64'(c1), 64'd2);
        end

        // Cycle limit 20 with a halt instruction on cycle 20: halt instr wins.
        watch_pattern = {32'hffffffff, 32'hffffffff};
        watch_mask    = {32'hffffffff, 32'hffffffff};
        start_run("t5a", 1'b1);
        for (int k = 1; k <= 22; k++) begin
            if (k < 20)
                run_cycle(32'd0, 32'h100 + 32'(4*k),
                          mk($sformatf("t5a.c%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, k, 2'b00, 0, 0, 1'b1));
            else
                run_cycle((k == 20) ? 32'h0000000d : 32'd0, 32'h100 + 32'(4*k),
                          mk($sformatf("t5a.c%0d", k), 1'b0, 1'b0, 1'b1, 2'd1, 20, 2'b00, 0, 0, 1'b1));
        end

        // Cycle limit 20 alone: cause 11 with cycle_count 20.
        start_run("t5b", 1'b1);
        for (int k = 1; k <= 22; k++) begin
            if (k < 20)
                run_cycle(32'd0, 32'h100 + 32'(4*k),
                          mk($sformatf("t5b.c%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, k, 2'b00, 0, 0, 1'b1));
            else
                run_cycle(32'd0, 32'h100 + 32'(4*k),
                          mk($sformatf("t5b.c%0d", k), 1'b0, 1'b0, 1'b1, 2'd3, 20, 2'b00, 0, 0, 1'b1));
        end

        // Reset pulsed on RUN cycle 7 with nonzero counts returns to HOLD, then restarts.
        watch_pattern = {32'h00000000, 32'hffffffff};
        watch_mask    = {32'h00000000, 32'hffffffff};
        start_run("t6", 1'b0);
        for (int k = 1; k <= 6; k++)
            run_cycle(32'd0, 32'h100 + 32'(4*k),
                      mk($sformatf("t6.c%0d", k), 1'b0, 1'b1, 1'b0, 2'd0, k, 2'b10, 0, k, 1'b0));
        reset = 1'b1;
        run_cycle(32'd0, 32'h11c, mk("t6.midrst", 1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, 0, 0, 1'b0));
        reset = 1'b0;
        run_cycle(32'd0, 32'h0, mk("t6.hold0", 1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, 0, 0, 1'b0));
        run_cycle(32'd0, 32'h0, mk("t6.hold1", 1'b1, 1'b0, 1'b0, 2'd0, 0, 2'b00, 0, 0, 1'b0));
        run_cycle(32'd0, 32'h0, mk("t6.go",    1'b0, 1'b1, 1'b0, 2'd0, 0, 2'b00, 0, 0, 1'b0));
        run_cycle(32'd0, 32'h4, mk("t6.c1",    1'b0, 1'b1, 1'b0, 2'd0, 1, 2'b10, 0, 1, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
